// File: rtl/wbuf_pkg.sv
// Shared definitions for the write buffer.
// Contents:
//   wbuf_state_t  FSM state encoding (IDLE, FETCH, DRAIN, RESP)
//   DEF_ADDR_W    default block address width
//   DEF_DATA_W    default block data width
//   clog2()       pointer-width helper usable in constant expressions
package wbuf_pkg;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DATA_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } wbuf_state_t;

  // Smallest r with (1 << r) >= n.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/write_buffer_if.sv
// Block bus used on both sides of the write buffer (cache side and memory side).
// Signals:
//   read, write  request strobes, held by the requester until ready
//   addr         block address
//   wdata        write data
//   rdata        read data, valid while ready=1
//   ready        one-cycle completion pulse from the responder
// Handshake: the master raises read or write with addr/wdata stable and holds
// them until it sees ready=1 for one cycle; that cycle completes the transfer
// (and carries rdata for a read). The master must drop the request after the
// ready cycle; the responder never pulses ready without a pending request.
// Modports: master = requester, slave = responder.
interface write_buffer_if
  import wbuf_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (
    output read, write, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  read, write, addr, wdata,
    output rdata, ready
  );

endinterface

// File: rtl/wbuf_fifo.sv
// Entry storage for the write buffer: circular FIFO of {addr, data} blocks
// with head/tail pointers and an occupancy count, plus a parallel address
// compare over all live entries that reports the youngest match.
// Ports:
//   clk, rst              clock, synchronous active-high reset (clears pointers/count)
//   push, push_addr/data  append a new tail entry
//   ow_en, ow_idx/data    overwrite the data of an existing entry in place
//   pop                   retire the head entry
//   lookup_addr           address compared against every live entry
//   hit, hit_idx, hit_data youngest live entry whose address equals lookup_addr
//   head_addr, head_data  oldest entry (next to drain)
//   count                 number of live entries, 0..DEPTH
module wbuf_fifo
  import wbuf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [ADDR_W-1:0]         push_addr,
  input  logic [DATA_W-1:0]         push_data,
  input  logic                      ow_en,
  input  logic [clog2(DEPTH)-1:0]   ow_idx,
  input  logic [DATA_W-1:0]         ow_data,
  input  logic                      pop,
  input  logic [ADDR_W-1:0]         lookup_addr,
  output logic                      hit,
  output logic [clog2(DEPTH)-1:0]   hit_idx,
  output logic [DATA_W-1:0]         hit_data,
  output logic [ADDR_W-1:0]         head_addr,
  output logic [DATA_W-1:0]         head_data,
  output logic [clog2(DEPTH):0]     count
);

  localparam int PTR_W = clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W:0]    cnt;
  logic [DEPTH-1:0]  match_vec;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + PTR_ONE;
      if (pop)  head <= head + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: liveness is defined by head/count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= push_addr;
      data_mem[tail] <= push_data;
    end
    if (ow_en) data_mem[ow_idx] <= ow_data;
  end

  // An entry is live when its distance from head is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    logic [PTR_W-1:0] age;
    assign age          = PTR_W'(i) - head;
    assign match_vec[i] = ({1'b0, age} < cnt) && (addr_mem[i] == lookup_addr);
  end

  // Walk from oldest slot (tail - DEPTH) to youngest (tail - 1); the last
  // match seen wins, giving the youngest matching entry.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (match_vec[tail - PTR_W'(k)]) begin
        hit     = 1'b1;
        hit_idx = tail - PTR_W'(k);
      end
    end
  end

  assign hit_data  = data_mem[hit_idx];
  assign head_addr = addr_mem[head];
  assign head_data = data_mem[head];
  assign count     = cnt;

endmodule

// File: rtl/write_buffer.sv
// Write buffer between the cache and main memory on the block bus.
// Cache write-backs are absorbed into a small FIFO and drained to memory when
// the cache is quiet. Reads hitting a buffered block are answered locally;
// reads missing the buffer go to memory ahead of pending drains.
// Ports:
//   clk          clock
//   proc_reset   synchronous active-high reset; clears the FIFO and aborts any
//                memory transfer in progress
//   cache        write_buffer_if.slave  - requests from the cache
//   mem          write_buffer_if.master - requests to main memory
//   wbuf_empty   FIFO holds no entries (registered)
//   dbg_state    current FSM state
//   dbg_count    current FIFO occupancy
// Build option: define WBUF_COALESCE_EN to merge a write into an existing
// entry with the same address instead of allocating a new one.
// All cache-/memory-facing outputs are registered.
module write_buffer
  import wbuf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                   clk,
  input  logic                   proc_reset,
  write_buffer_if.slave          cache,
  write_buffer_if.master         mem,
  output logic                   wbuf_empty,
  output wbuf_state_t            dbg_state,
  output logic [clog2(DEPTH):0]  dbg_count
);

  localparam int PTR_W = clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);

  wbuf_state_t state_q, state_d;

  logic [DATA_W-1:0] c_rdata_q,   c_rdata_d;
  logic              c_ready_q,   c_ready_d;
  logic              mem_read_q,  mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              empty_q,     empty_d;

  logic              push;
  logic              pop;
  logic              ow_en;
  logic              hit;
  logic [PTR_W-1:0]  hit_idx;
  logic [DATA_W-1:0] hit_data;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [PTR_W:0]    fifo_count;

  wbuf_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (proc_reset),
    .push        (push),
    .push_addr   (cache.addr),
    .push_data   (cache.wdata),
    .ow_en       (ow_en),
    .ow_idx      (hit_idx),
    .ow_data     (cache.wdata),
    .pop         (pop),
    .lookup_addr (cache.addr),
    .hit         (hit),
    .hit_idx     (hit_idx),
    .hit_data    (hit_data),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .count       (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q     <= ST_IDLE;
      c_rdata_q   <= '0;
      c_ready_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      empty_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      c_rdata_q   <= c_rdata_d;
      c_ready_q   <= c_ready_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      empty_q     <= empty_d;
    end
  end

  // Requests are only sampled in IDLE, so FIFO pushes/overwrites never
  // happen while DRAIN is reading the head entry.
  always_comb begin
    state_d     = state_q;
    c_rdata_d   = c_rdata_q;
    c_ready_d   = 1'b0;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    empty_d     = empty_q;
    push        = 1'b0;
    pop         = 1'b0;
    ow_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A read wins over a simultaneous write; the write is dropped.
        if (cache.read && hit) begin
          c_rdata_d = hit_data;
          c_ready_d = 1'b1;
          state_d   = ST_RESP;
        end else if (cache.read) begin
          mem_read_d = 1'b1;
          mem_addr_d = cache.addr;
          state_d    = ST_FETCH;
        end else if (cache.write && (fifo_count < FULL_CNT)) begin
`ifdef WBUF_COALESCE_EN
          if (hit) ow_en = 1'b1;
          else     push  = 1'b1;
`else
          push = 1'b1;
`endif
          c_ready_d = 1'b1;
          state_d   = ST_RESP;
        end else if (fifo_count != '0) begin
          // Also covers a write arriving while full: drain first, then the
          // held write is accepted on the next IDLE evaluation.
          mem_write_d = 1'b1;
          mem_addr_d  = head_addr;
          mem_wdata_d = head_data;
          state_d     = ST_DRAIN;
        end
      end

      ST_FETCH: begin
        if (mem.ready) begin
          c_rdata_d  = mem.rdata;
          c_ready_d  = 1'b1;
          mem_read_d = 1'b0;
          state_d    = ST_RESP;
        end
      end

      ST_DRAIN: begin
        if (mem.ready) begin
          mem_write_d = 1'b0;
          pop         = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      ST_RESP: begin
        // Dead cycle so the cache can drop its request before the next sample.
        c_rdata_d = '0;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (push)     empty_d = 1'b0;
    else if (pop) empty_d = (fifo_count == CNT_ONE);
  end

  assign cache.rdata = c_rdata_q;
  assign cache.ready = c_ready_q;
  assign mem.read    = mem_read_q;
  assign mem.write   = mem_write_q;
  assign mem.addr    = mem_addr_q;
  assign mem.wdata   = mem_wdata_q;
  assign wbuf_empty  = empty_q;
  assign dbg_state   = state_q;
  assign dbg_count   = fifo_count;

endmodule

// File: tb/tb_write_buffer.sv
// Self-checking bench for write_buffer (DEPTH=4).
// Expected cache responses and expected memory transactions are queued by
// the stimulus; the cache monitor and the memory responder pop and compare.
module tb_write_buffer;
  import wbuf_pkg::*;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int TW = 1 + AW + DW;

  logic clk = 1'b0;
  logic proc_reset;
  logic wbuf_empty;
  wbuf_state_t dbg_state;
  logic [2:0] dbg_count;

  write_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) cache_bus ();
  write_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

  write_buffer #(.DEPTH(4), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .cache      (cache_bus),
    .mem        (mem_bus),
    .wbuf_empty (wbuf_empty),
    .dbg_state  (dbg_state),
    .dbg_count  (dbg_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];       // expected c_rdata per c_ready pulse
  logic [TW-1:0] mem_exp_q[$];   // expected {is_write, addr, wdata} per memory transfer

  int mem_lat = 3;
  logic mem_hold = 1'b0;
  int mem_wait = 0;
  int last_ready_cyc = 0;

  localparam logic [DW-1:0] D1 = {4{32'h1111_0001}};
  localparam logic [DW-1:0] D2 = {4{32'h2222_0002}};
  localparam logic [DW-1:0] D3 = {4{32'h3333_0003}};

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return {4{4'hC, a}};
  endfunction

  function automatic logic [DW-1:0] wr_data(input logic [AW-1:0] a);
    return {4{4'h5, a}};
  endfunction

  function automatic logic [TW-1:0] mk_txn(input logic wr, input logic [AW-1:0] a,
                                           input logic [DW-1:0] d);
    return {wr, a, d};
  endfunction

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- cache-side monitor ----------------
  always @(negedge clk) begin
    if (!proc_reset && cache_bus.ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL c_ready_unexpected: got rdata %h expected no response", cache_bus.rdata);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (cache_bus.rdata !== e) begin
          errors++;
          $display("FAIL c_rdata: got %h expected %h", cache_bus.rdata, e);
        end
      end
    end
  end

  // ---------------- memory responder / monitor ----------------
  initial begin
    mem_bus.ready = 1'b0;
    mem_bus.rdata = '0;
    forever begin
      @(negedge clk);
      mem_bus.ready = 1'b0;
      mem_bus.rdata = '0;
      if (proc_reset || !(mem_bus.read || mem_bus.write)) begin
        mem_wait = 0;
      end else if (mem_hold || mem_wait < mem_lat) begin
        mem_wait++;
      end else begin
        logic [TW-1:0] got;
        logic [TW-1:0] e;
        mem_wait = 0;
        mem_bus.ready = 1'b1;
        mem_bus.rdata = mem_bus.read ? mem_data(mem_bus.addr) : '0;
        last_ready_cyc = cyc;
        got = mk_txn(mem_bus.write, mem_bus.addr, mem_bus.write ? mem_bus.wdata : '0);
        checks++;
        if (mem_exp_q.size() == 0) begin
          errors++;
          $display("FAIL mem_unexpected: got %h expected no transfer", got);
        end else begin
          e = mem_exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL mem_txn: got %h expected %h", got, e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic rd, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    @(negedge clk);
    cache_bus.read  = rd;
    cache_bus.write = wr;
    cache_bus.addr  = a;
    cache_bus.wdata = d;
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cache_bus.ready && lat < 200);
    checks++;
    if (!cache_bus.ready) begin
      errors++;
      $display("FAIL c_ready_timeout: got no c_ready after %0d cycles expected a response", lat);
    end
    cache_bus.read  = 1'b0;
    cache_bus.write = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int exp_lat);
    int lat;
    exp_q.push_back('0);
    drive_req(1'b0, 1'b1, a, d);
    wait_ready(lat);
    if (exp_lat >= 0) check_val("write_latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp_d, input int exp_lat);
    int lat;
    exp_q.push_back(exp_d);
    drive_req(1'b1, 1'b0, a, '0);
    wait_ready(lat);
    if (exp_lat >= 0) check_val("read_latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(wbuf_empty && dbg_state == ST_IDLE) && n < 300);
    check_val("drained_empty", 64'(wbuf_empty), 64'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic saw_ready;
    int n;

    cache_bus.read  = 1'b0;
    cache_bus.write = 1'b0;
    cache_bus.addr  = '0;
    cache_bus.wdata = '0;
    proc_reset = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check_val("rst_wbuf_empty", 64'(wbuf_empty), 64'd1);
    check_val("rst_c_ready", 64'(cache_bus.ready), 64'd0);
    check_val("rst_c_rdata", 64'(cache_bus.rdata), 64'd0);
    check_val("rst_mem_read", 64'(mem_bus.read), 64'd0);
    check_val("rst_mem_write", 64'(mem_bus.write), 64'd0);
    check_val("rst_mem_addr", 64'(mem_bus.addr), 64'd0);
    check_val("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    proc_reset = 1'b0;

    // 1: single write then drain
    mem_exp_q.push_back(mk_txn(1'b1, 28'h10, D1));
    do_write(28'h10, D1, 1);
    check_val("t1_not_empty", 64'(wbuf_empty), 64'd0);
    check_val("t1_count", 64'(dbg_count), 64'd1);
    wait_empty();
    check_val("t1_count_after", 64'(dbg_count), 64'd0);

    // 2: read forwarded from the buffer, no memory read
    mem_exp_q.push_back(mk_txn(1'b1, 28'h10, D1));
    do_write(28'h10, D1, 1);
    do_read(28'h10, D1, 1);
    wait_empty();

    // 3: fill, stall fifth write behind a held drain
    mem_hold = 1'b1;
    for (int a = 1; a <= 5; a++) mem_exp_q.push_back(mk_txn(1'b1, AW'(a), wr_data(AW'(a))));
    for (int a = 1; a <= 4; a++) do_write(AW'(a), wr_data(AW'(a)), 1);
    check_val("t3_full_count", 64'(dbg_count), 64'd4);
    exp_q.push_back('0);
    drive_req(1'b0, 1'b1, 28'h5, wr_data(28'h5));
    saw_ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (cache_bus.ready) saw_ready = 1'b1;
    end
    check_val("t3_stall_no_ready", 64'(saw_ready), 64'd0);
    check_val("t3_drain_write", 64'(mem_bus.write), 64'd1);
    check_val("t3_drain_addr", 64'(mem_bus.addr), 64'h1);
    check_val("t3_state_drain", 64'(dbg_state), 64'(ST_DRAIN));
    mem_hold = 1'b0;
    wait_ready(lat);
    check_val("t3_count_after_accept", 64'(dbg_count), 64'd4);
    wait_empty();

    // 4: missing read goes ahead of a pending drain
    mem_exp_q.push_back(mk_txn(1'b0, 28'h30, '0));
    mem_exp_q.push_back(mk_txn(1'b1, 28'h20, D3));
    do_write(28'h20, D3, 1);
    do_read(28'h30, mem_data(28'h30), -1);
    check_val("t4_fetch_latency", 64'(cyc - last_ready_cyc), 64'd1);
    wait_empty();

    // 5: two writes to the same address
`ifdef WBUF_COALESCE_EN
    mem_exp_q.push_back(mk_txn(1'b1, 28'h40, D2));
`else
    mem_exp_q.push_back(mk_txn(1'b1, 28'h40, D1));
    mem_exp_q.push_back(mk_txn(1'b1, 28'h40, D2));
`endif
    do_write(28'h40, D1, 1);
    do_write(28'h40, D2, 1);
`ifdef WBUF_COALESCE_EN
    check_val("t5_count", 64'(dbg_count), 64'd1);
`else
    check_val("t5_count", 64'(dbg_count), 64'd2);
`endif
    do_read(28'h40, D2, 1);
    wait_empty();

    // 7: read and write together act as a read only
    mem_exp_q.push_back(mk_txn(1'b0, 28'h60, '0));
    exp_q.push_back(mem_data(28'h60));
    drive_req(1'b1, 1'b1, 28'h60, D1);
    wait_ready(lat);
    @(negedge clk);
    check_val("t7_count", 64'(dbg_count), 64'd0);
    check_val("t7_empty", 64'(wbuf_empty), 64'd1);

    // 6: reset during DRAIN
    mem_hold = 1'b1;
    do_write(28'h50, D3, 1);
    n = 0;
    while (!mem_bus.write && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("t6_in_drain", 64'(mem_bus.write), 64'd1);
    proc_reset = 1'b1;
    @(negedge clk);
    check_val("t6_mem_write", 64'(mem_bus.write), 64'd0);
    check_val("t6_c_ready", 64'(cache_bus.ready), 64'd0);
    check_val("t6_empty", 64'(wbuf_empty), 64'd1);
    check_val("t6_state", 64'(dbg_state), 64'(ST_IDLE));
    check_val("t6_count", 64'(dbg_count), 64'd0);
    proc_reset = 1'b0;
    mem_hold = 1'b0;
    repeat (20) @(negedge clk);

    check_val("left_cache_exp", 64'(exp_q.size()), 64'd0);
    check_val("left_mem_exp", 64'(mem_exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
